icache_dm: RTL and testbench
============================

// Module: icache_dm
// PURPOSE
//  Direct-mapped, read-only instruction cache in the fetch stage. Sits between the pipelined
//  core's fetch port (pcF -> instrF) and a multi-cycle main-memory read port.
//  Hits return the instruction combinationally in the same cycle. Misses assert stallF and
//  run a line-refill FSM that fetches WORDS_PER_LINE sequential words.
// PARAMETERS
//  LINES           16  number of cache lines; power of two, >= 2
//  WORDS_PER_LINE  4   32-bit words per line; power of two, >= 2
// PORTS
//  clk         in   1   single clock; all state updates on rising edge
//  reset       in   1   asynchronous, active-high reset
//  pcF         in   32  fetch address from core; bits [1:0] ignored
//  instrF      out  32  fetched instruction; 32'h0 (nop) whenever stallF=1
//  stallF      out  1   1 = instrF not valid this cycle; core holds pcF and freezes F/D
//  invalidate  in   1   1-cycle pulse: clear all valid bits
//  mem_req     out  1   read request to main memory; held high for the entire refill
//  mem_addr    out  32  word address of the current refill beat (bits [1:0] = 0)
//  mem_ready   in   1   current beat's data is valid on mem_rdata; ignored when mem_req=0
//  mem_rdata   in   32  refill data
// BEHAVIOUR
//  Address split: OFF_W = log2(WORDS_PER_LINE), IDX_W = log2(LINES).
//   word = pcF[2+OFF_W-1:2]; idx = pcF[2+OFF_W+IDX_W-1:2+OFF_W]; tag = remaining upper bits.
//   Tag width at defaults = 24.
//  hit = (state==IDLE) & valid[idx] & (tag_arr[idx]==tag)   (combinational).
//   instrF = hit ? data[idx][word] : 0.   stallF = ~hit.
//  Reset (async): state=IDLE; all valid=0; beat counter=0; mem_req=0; mem_addr=0.
//   instrF=0 and stallF=1 until the first refill completes.
//   Data and tag arrays are not reset.
//  FSM states: IDLE, FILL, COMMIT.
//   IDLE:
//    - On a miss: latch line base = {pcF[31:2+OFF_W], 0}; beat counter cnt=0; go to FILL.
//    - Miss is detected and FILL is entered on the same edge; stallF=1 in the miss cycle.
//   FILL:
//    - mem_req=1; mem_addr = line_base + 4*cnt.
//    - Each cycle with mem_ready=1: write mem_rdata to data[line_idx][cnt]; cnt++.
//    - On the beat with cnt==WORDS_PER_LINE-1 and mem_ready=1: go to COMMIT.
//    - mem_ready=0 cycles are wait states; no counter change.
//    - mem_req and mem_addr are registered outputs.
//   COMMIT (1 cycle):
//    - mem_req=0.
//    - tag_arr[line_idx] <= latched tag; valid[line_idx] <= ~inv_pending.
//    - Go to IDLE; the re-lookup in IDLE hits on the following cycle.
//  Minimum miss penalty: W + 2 stalled cycles with zero-wait memory (W = WORDS_PER_LINE):
//   miss cycle, W FILL beats, COMMIT. Hit data appears in the cycle after COMMIT.
//  Refill address comes only from the latched line base; pcF changes during FILL/COMMIT
//   are ignored.
//  invalidate:
//   - In IDLE: all valid bits clear at the edge; the same-cycle lookup still uses the old
//     valid bits.
//   - In FILL/COMMIT: set inv_pending. The line being filled is then not marked valid, and
//     all valid bits are cleared in COMMIT. inv_pending clears on leaving COMMIT.
//  Conflict eviction: a refill overwrites the line unconditionally; there is no dirty state.
//  Reset mid-FILL: mem_req drops to 0 asynchronously; the partial line stays invalid.
//   Memory must tolerate request withdrawal.
//  Index wrap: line_base + 4*cnt never crosses a line boundary. cnt is OFF_W bits and
//   never wraps inside FILL.
// STRUCTURE
//  Shared package mips_pkg:
//   - typedef enum logic [1:0] {IC_IDLE, IC_FILL, IC_COMMIT} icache_state_t;
//   - function clog2-based width constants.
//  Sub-module icache_mem:
//   - Tag + data arrays.
//   - Async read port indexed by idx/word.
//   - Sync word-write port for refill beats; sync tag write in COMMIT.
//   - Valid bits live in icache_dm so async reset and flash-clear stay local.
// TESTING
//  1 Cold miss: reset, pcF=0x0040, zero-wait memory returning addr^0xA5A5_0000.
//    -> mem_addr 0x40,0x44,0x48,0x4C; stallF=1 for 6 cycles; then instrF=0xA5A5_0040.
//  2 Hit: after test 1, pcF=0x004C.
//    -> same cycle stallF=0, instrF=0xA5A5_004C, mem_req=0.
//  3 Conflict: pcF=0x0440 (same idx, new tag) -> full refill.
//    Then pcF=0x0040 -> refill again.
//  4 Wait states: mem_ready toggles 1,0,0,1,0,1,1.
//    -> exactly 4 captures in order; stallF releases only after COMMIT.
//  5 Invalidate: pulse in IDLE -> next access to 0x0040 misses.
//    Pulse during FILL -> filled line not valid; re-access refills.
//  6 Reset at 2nd beat of FILL -> mem_req=0 in the same cycle;
//    after release, pcF=0x0040 misses and refills from word 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and address-split helpers for the fetch-stage instruction cache.
// Widths are derived from the cache geometry so the RTL and the bench agree on one split.
package mips_pkg;

    typedef enum logic [1:0] {
        IC_IDLE,
        IC_FILL,
        IC_COMMIT
    } icache_state_t;

    localparam int IC_WORD_W = 32;

    function automatic int ic_off_w(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int ic_idx_w(input int lines);
        return $clog2(lines);
    endfunction

    // Byte offset (2 bits) + word offset + index are stripped from a 32-bit address.
    function automatic int ic_tag_w(input int lines, input int words_per_line);
        return 30 - $clog2(lines) - $clog2(words_per_line);
    endfunction

endpackage

// File: rtl/icache_mem.sv
// Tag and data storage for the direct-mapped instruction cache.
// Asynchronous lookup read, synchronous refill-word and tag writes; contents are never reset.
module icache_mem
    import mips_pkg::*;
#(
    parameter int  LINES          = 16,
    parameter int  WORDS_PER_LINE = 4,
    localparam int OFF_W          = ic_off_w(WORDS_PER_LINE),
    localparam int IDX_W          = ic_idx_w(LINES),
    localparam int TAG_W          = ic_tag_w(LINES, WORDS_PER_LINE)
) (
    input  logic                 clk,
    input  logic [IDX_W-1:0]     rd_idx,
    input  logic [OFF_W-1:0]     rd_word,
    output logic [TAG_W-1:0]     rd_tag,
    output logic [IC_WORD_W-1:0] rd_data,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [OFF_W-1:0]     wr_word,
    input  logic [IC_WORD_W-1:0] wr_data,
    input  logic                 tag_we,
    input  logic [IDX_W-1:0]     tag_idx,
    input  logic [TAG_W-1:0]     tag_data
);

    logic [IC_WORD_W-1:0] data_arr [LINES][WORDS_PER_LINE];
    logic [TAG_W-1:0]     tag_arr  [LINES];

    assign rd_tag  = tag_arr[rd_idx];
    assign rd_data = data_arr[rd_idx][rd_word];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_arr[wr_idx][wr_word] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_arr[tag_idx] <= tag_data;
        end
    end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: combinational hit path, line-refill FSM on miss.
//   state     | meaning
//   IC_IDLE   | lookup; a miss latches the line base and starts a refill
//   IC_FILL   | mem_req high, one word captured per mem_ready beat
//   IC_COMMIT | write tag, set (or flash-clear) valid bits, return to lookup
module icache_dm
    import mips_pkg::*;
#(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pcF,
    output logic [31:0] instrF,
    output logic        stallF,
    input  logic        invalidate,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int OFF_W = ic_off_w(WORDS_PER_LINE);
    localparam int IDX_W = ic_idx_w(LINES);
    localparam int TAG_W = ic_tag_w(LINES, WORDS_PER_LINE);
    localparam int HI_W  = IDX_W + TAG_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

    icache_state_t    state;
    icache_state_t    state_next;
    logic [LINES-1:0] valid;
    logic [OFF_W-1:0] cnt;
    logic [HI_W-1:0]  line_hi;
    logic             inv_pending;

    logic [OFF_W-1:0] pc_word;
    logic [IDX_W-1:0] pc_idx;
    logic [TAG_W-1:0] pc_tag;
    logic [IDX_W-1:0] line_idx;
    logic [TAG_W-1:0] line_tag;
    logic [31:0]      miss_base;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_data;
    logic             hit;
    logic             last_beat;
    logic             unused_pc_byte;

    assign pc_word   = pcF[2 +: OFF_W];
    assign pc_idx    = pcF[2 + OFF_W +: IDX_W];
    assign pc_tag    = pcF[31 -: TAG_W];
    assign line_idx  = line_hi[IDX_W-1:0];
    assign line_tag  = line_hi[IDX_W +: TAG_W];
    assign miss_base = {pcF[31:2+OFF_W], {(2 + OFF_W){1'b0}}};
    assign unused_pc_byte = ^pcF[1:0];

    icache_mem #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_mem (
        .clk      (clk),
        .rd_idx   (pc_idx),
        .rd_word  (pc_word),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    ((state == IC_FILL) && mem_ready),
        .wr_idx   (line_idx),
        .wr_word  (cnt),
        .wr_data  (mem_rdata),
        .tag_we   (state == IC_COMMIT),
        .tag_idx  (line_idx),
        .tag_data (line_tag)
    );

    assign hit       = (state == IC_IDLE) && valid[pc_idx] && (rd_tag == pc_tag);
    assign instrF    = hit ? rd_data : 32'h0;
    assign stallF    = ~hit;
    assign last_beat = mem_ready && (cnt == LAST_BEAT);

    always_comb begin
        state_next = state;
        case (state)
            IC_IDLE:   if (!hit) state_next = IC_FILL;
            IC_FILL:   if (last_beat) state_next = IC_COMMIT;
            IC_COMMIT: state_next = IC_IDLE;
            default:   state_next = IC_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IC_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Refill datapath; mem_addr advances one word per accepted beat and holds on wait states.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid       <= '0;
            cnt         <= '0;
            line_hi     <= '0;
            inv_pending <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= 32'h0;
        end else begin
            case (state)
                IC_IDLE: begin
                    if (invalidate) valid <= '0;
                    if (!hit) begin
                        line_hi  <= pcF[31:2+OFF_W];
                        cnt      <= '0;
                        mem_req  <= 1'b1;
                        mem_addr <= miss_base;
                    end
                end
                IC_FILL: begin
                    if (invalidate) inv_pending <= 1'b1;
                    if (mem_ready) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_BEAT) begin
                            mem_req <= 1'b0;
                        end else begin
                            mem_addr <= mem_addr + 32'd4;
                        end
                    end
                end
                IC_COMMIT: begin
                    // A late invalidate landing in COMMIT itself must still win.
                    if (inv_pending || invalidate) begin
                        valid <= '0;
                    end else begin
                        valid[line_idx] <= 1'b1;
                    end
                    inv_pending <= 1'b0;
                end
                default: begin
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: memory returns addr ^ 32'hA5A5_0000 so every expected word
// follows from its address.
module tb_icache_dm;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pcF;
    logic [31:0] instrF;
    logic        stallF;
    logic        invalidate;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    logic [31:0] beat_q[$];
    logic        ready_pat[$];
    int          stall_cycles;
    logic        stall_nonzero;

    always #5 clk = ~clk;

    always_comb mem_rdata = mem_addr ^ 32'hA5A5_0000;

    icache_dm #(.LINES(16), .WORDS_PER_LINE(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .pcF        (pcF),
        .instrF     (instrF),
        .stallF     (stallF),
        .invalidate (invalidate),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs from posedge+1 until stallF drops, logging captured beat addresses.
    task automatic wait_hit(input string name);
        bit done = 0;
        beat_q.delete();
        stall_cycles  = 0;
        stall_nonzero = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            if (mem_req) mem_ready = (ready_pat.size() > 0) ? ready_pat.pop_front() : 1'b1;
            #1;
            if (!stallF) begin
                done = 1;
            end else begin
                if (instrF !== 32'h0) stall_nonzero = 1'b1;
                if (mem_req && mem_ready) beat_q.push_back(mem_addr);
                stall_cycles++;
                tick();
            end
        end
        mem_ready = 1'b1;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout: stallF still %0b after 60 cycles, required 0", name, stallF);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; pcF = 32'h40; invalidate = 1'b0; mem_ready = 1'b1;
        tick(); tick();
        checks++;
        if (stallF !== 1'b1 || instrF !== 32'h0) begin
            errors++;
            $display("FAIL reset_out: stallF=%0b instrF=%h, required 1/00000000", stallF, instrF);
        end
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem: mem_req=%0b mem_addr=%h, required 0/00000000", mem_req, mem_addr);
        end
        reset = 1'b0;
    endtask

    task automatic test_cold_miss();
        pcF = 32'h40;
        wait_hit("cold");
        checks++;
        if (stall_cycles !== 6) begin
            errors++;
            $display("FAIL cold_stall: %0d cycles, required 6", stall_cycles);
        end
        checks++;
        if (beat_q.size() !== 4 || beat_q[0] !== 32'h40 || beat_q[1] !== 32'h44 ||
            beat_q[2] !== 32'h48 || beat_q[3] !== 32'h4C) begin
            errors++;
            $display("FAIL cold_addrs: %0d beats first=%h, required 4 beats 40,44,48,4c",
                     beat_q.size(), (beat_q.size() > 0) ? beat_q[0] : 32'hx);
        end
        checks++;
        if (instrF !== 32'hA5A5_0040 || stall_nonzero) begin
            errors++;
            $display("FAIL cold_data: instrF=%h stall_nonzero=%0b, required a5a50040/0",
                     instrF, stall_nonzero);
        end
    endtask

    task automatic test_hit();
        pcF = 32'h4C;
        #1;
        checks++;
        if (stallF !== 1'b0 || instrF !== 32'hA5A5_004C || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL hit_4c: stallF=%0b instrF=%h mem_req=%0b, required 0/a5a5004c/0",
                     stallF, instrF, mem_req);
        end
        pcF = 32'h44;
        #1;
        checks++;
        if (stallF !== 1'b0 || instrF !== 32'hA5A5_0044) begin
            errors++;
            $display("FAIL hit_44: stallF=%0b instrF=%h, required 0/a5a50044", stallF, instrF);
        end
        tick();
    endtask

    task automatic test_conflict();
        pcF = 32'h440;
        wait_hit("conflict_a");
        checks++;
        if (stall_cycles !== 6 || beat_q.size() !== 4 || beat_q[0] !== 32'h440 ||
            instrF !== 32'hA5A5_0440) begin
            errors++;
            $display("FAIL conflict_a: cycles=%0d beats=%0d instrF=%h, required 6/4/a5a50440",
                     stall_cycles, beat_q.size(), instrF);
        end
        tick();
        pcF = 32'h40;
        wait_hit("conflict_b");
        checks++;
        if (stall_cycles !== 6 || beat_q.size() !== 4 || beat_q[3] !== 32'h4C ||
            instrF !== 32'hA5A5_0040) begin
            errors++;
            $display("FAIL conflict_b: cycles=%0d beats=%0d instrF=%h, required 6/4/a5a50040",
                     stall_cycles, beat_q.size(), instrF);
        end
        tick();
    endtask

    task automatic test_wait_states();
        ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        pcF = 32'h8C;
        wait_hit("wait");
        checks++;
        if (stall_cycles !== 9) begin
            errors++;
            $display("FAIL wait_stall: %0d cycles, required 9", stall_cycles);
        end
        checks++;
        if (beat_q.size() !== 4 || beat_q[0] !== 32'h80 || beat_q[1] !== 32'h84 ||
            beat_q[2] !== 32'h88 || beat_q[3] !== 32'h8C) begin
            errors++;
            $display("FAIL wait_addrs: %0d beats, required 4 beats 80,84,88,8c", beat_q.size());
        end
        checks++;
        if (instrF !== 32'hA5A5_008C) begin
            errors++;
            $display("FAIL wait_data: instrF=%h, required a5a5008c", instrF);
        end
        tick();
    endtask

    task automatic test_invalidate();
        pcF = 32'h80;
        invalidate = 1'b1;
        #1;
        checks++;
        if (stallF !== 1'b0 || instrF !== 32'hA5A5_0080) begin
            errors++;
            $display("FAIL inv_same_cycle: stallF=%0b instrF=%h, required 0/a5a50080", stallF, instrF);
        end
        tick();
        invalidate = 1'b0;
        #1;
        checks++;
        if (stallF !== 1'b1) begin
            errors++;
            $display("FAIL inv_idle_miss: stallF=%0b, required 1", stallF);
        end
        wait_hit("inv_refill");
        checks++;
        if (stall_cycles !== 6 || instrF !== 32'hA5A5_0080) begin
            errors++;
            $display("FAIL inv_refill: cycles=%0d instrF=%h, required 6/a5a50080", stall_cycles, instrF);
        end
        tick();
        // Invalidate during the first FILL beat of line 0xC0.
        pcF = 32'hC0;
        tick();
        invalidate = 1'b1;
        tick();
        invalidate = 1'b0;
        wait_hit("inv_fill");
        checks++;
        if (stall_cycles !== 10 || beat_q.size() !== 7 || beat_q[0] !== 32'hC4 ||
            beat_q[3] !== 32'hC0) begin
            errors++;
            $display("FAIL inv_fill_refill: cycles=%0d beats=%0d, required 10/7 restarting at c0",
                     stall_cycles, beat_q.size());
        end
        checks++;
        if (instrF !== 32'hA5A5_00C0) begin
            errors++;
            $display("FAIL inv_fill_data: instrF=%h, required a5a500c0", instrF);
        end
        pcF = 32'h80;
        #1;
        checks++;
        if (stallF !== 1'b1) begin
            errors++;
            $display("FAIL inv_fill_flash: stallF=%0b on 0x80, required 1", stallF);
        end
        tick();
    endtask

    task automatic test_reset_mid_fill();
        pcF = 32'h40;
        wait_hit("pre_reset");
        tick();
        pcF = 32'h40;
        #1;
        // 0x80 refill from the previous task is in flight or done; start a fresh miss on 0x100.
        pcF = 32'h100;
        tick();
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || stallF !== 1'b1) begin
            errors++;
            $display("FAIL reset_fill: mem_req=%0b stallF=%0b, required 0/1", mem_req, stallF);
        end
        tick();
        reset = 1'b0;
        pcF = 32'h40;
        wait_hit("post_reset");
        checks++;
        if (stall_cycles !== 6 || beat_q.size() !== 4 || beat_q[0] !== 32'h40 ||
            instrF !== 32'hA5A5_0040) begin
            errors++;
            $display("FAIL post_reset: cycles=%0d beats=%0d instrF=%h, required 6/4/a5a50040",
                     stall_cycles, beat_q.size(), instrF);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcs[4];
        pcs = '{32'h40, 32'h48, 32'h44, 32'h4C};
        for (int i = 0; i < 4; i++) begin
            pcF = pcs[i];
            #1;
            checks++;
            if (stallF !== 1'b0 || instrF !== (pcs[i] ^ 32'hA5A5_0000)) begin
                errors++;
                $display("FAIL b2b_%0d: stallF=%0b instrF=%h, required 0/%h",
                         i, stallF, instrF, pcs[i] ^ 32'hA5A5_0000);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_wait_states();
        test_invalidate();
        test_reset_mid_fill();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
